mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester controller for the shared multi-cycle data RAM in the Tomasulo core.
- The load buffer (read port) and store buffer (write port) compete for the single RAM. The arbiter grants one request at a time.
- While a request is in flight, the arbiter holds the RAM address, data and strobes stable. It waits for the RAM completion status, then returns data/ack to the winning requester.

Parameters:
- PRIO_STORE, 0: 0 = round-robin between load and store; 1 = store always wins on simultaneous request.
- TIMEOUT_CYC, 64: wait-state cycle limit before abort. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- ld_req  in  1  load request. Held high with ld_addr stable until ld_ack.
- ld_addr  in  32  load byte address.
- ld_ack  out  1  one-cycle pulse: ld_data valid.
- ld_data  out  32  read data. Registered; holds until next load completes.
- st_req  in  1  store request. Held high with st_addr/st_data stable until st_ack.
- st_addr  in  32  store byte address.
- st_data  in  32  store data; byte [31:24] goes to the lowest address.
- st_ack  out  1  one-cycle pulse: store committed.
- mem_address  out  32  RAM address.
- mem_writeData  out  32  RAM write data.
- mem_nRD  out  1  RAM read strobe, active low.
- mem_nWR  out  1  RAM write strobe, active low.
- mem_Dataout  in  32  RAM read data.
- mem_readStatus  in  1  RAM read complete, high = Dataout valid.
- mem_writeStatus  in  1  RAM write complete.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse: timed-out transaction. Tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset values (synchronous, active-high):
  - state = IDLE, mem_nRD = 1, mem_nWR = 1.
  - mem_address = 0, mem_writeData = 0, ld_data = 0.
  - ld_ack = 0, st_ack = 0, busy = 0, err = 0.
  - last_grant = store, so the first tie goes to load in round-robin mode.
- Reset mid-transaction immediately deasserts both strobes, drops any pending ack, and returns to IDLE.
- States: IDLE, RD_WAIT, WR_WAIT, RELEASE.
- IDLE: requests are sampled only in this state.
  - Load only: latch ld_addr into mem_address, mem_nRD <= 0, go to RD_WAIT.
  - Store only: latch st_addr/st_data into mem_address/mem_writeData, mem_nWR <= 0, go to WR_WAIT.
  - Both requesting:
    - PRIO_STORE = 1: store wins.
    - PRIO_STORE = 0: the side that did not win last wins; update last_grant on every grant.
- RD_WAIT: hold all mem_* outputs constant.
  - On mem_readStatus = 1: ld_data <= mem_Dataout, ld_ack <= 1, mem_nRD <= 1, go to RELEASE.
- WR_WAIT: symmetric to RD_WAIT.
  - On mem_writeStatus = 1: st_ack <= 1, mem_nWR <= 1, go to RELEASE.
- RELEASE: exactly one cycle. Acks return to 0, then go to IDLE.
  - This cycle lets the requester drop req or present a new one.
  - Minimum spacing between grants is therefore 2 cycles after completion.
- Latency: grant is 1 cycle after req is seen in IDLE. Ack is 1 cycle after the status is sampled high.
- At most one strobe is low at any time. mem_nRD and mem_nWR are never both 0.
- A req dropped before ack is protocol violation; the transaction still completes and the ack is still issued.
- A status already high on entry to a wait state counts as completion on the first wait cycle.
- Status of the non-active type is ignored.
- Address is forwarded unmodified; no alignment checks.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - An 8-bit wait counter clears on entry to RD_WAIT/WR_WAIT and increments every wait cycle.
  - When it reaches TIMEOUT_CYC without status: deassert the strobe, pulse err and the matching ack together (ld_data unchanged), go to RELEASE.
- Disabled: no counter; err is constant 0; wait states wait indefinitely.

Decomposition:
- Shared package mem_pkg holds:
  - state encoding constants: ARB_IDLE = 2'd0, ARB_RD = 2'd1, ARB_WR = 2'd2, ARB_REL = 2'd3;
  - GRANT_LD / GRANT_ST;
  - WORD_W = 32.
- One natural sub-module, arb_pick: combinational 2-way winner select from ld_req, st_req, last_grant and PRIO_STORE.
- The FSM, latching and timeout logic stay in mem_arbiter.

Test Plan:
- Load alone: ld_req = 1, ld_addr = 0x8, RAM model returns 0xDEADBEEF after 10 cycles -> mem_nRD low from grant to completion, mem_address = 0x8 stable throughout, ld_ack one pulse, ld_data = 0xDEADBEEF.
- Store then load same address: st 0x10 <= 0x12345678, then ld 0x10 -> st_ack first, then ld_data = 0x12345678; strobes never overlap.
- Simultaneous req, PRIO_STORE = 0, both held for 3 transactions -> grant order load, store, load; at least 1 RELEASE cycle between transactions.
- Simultaneous req, PRIO_STORE = 1 -> store granted first every tie.
- Reset asserted during RD_WAIT -> next cycle mem_nRD = 1, busy = 0, no ld_ack.
- ARB_TIMEOUT_EN, TIMEOUT_CYC = 16, RAM never completes -> after 16 wait cycles err and ld_ack pulse together, mem_nRD = 1, ld_data unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and types for the data RAM arbiter
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2,
    ARB_REL  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_LD = 1'b0,
    GRANT_ST = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - load/store request ports and RAM bus bundled for the arbiter
interface mem_arbiter_if import mem_pkg::*; ();

  logic              ld_req;
  logic [WORD_W-1:0] ld_addr;
  logic              ld_ack;
  logic [WORD_W-1:0] ld_data;
  logic              st_req;
  logic [WORD_W-1:0] st_addr;
  logic [WORD_W-1:0] st_data;
  logic              st_ack;
  logic [WORD_W-1:0] mem_address;
  logic [WORD_W-1:0] mem_writeData;
  logic              mem_nRD;
  logic              mem_nWR;
  logic [WORD_W-1:0] mem_Dataout;
  logic              mem_readStatus;
  logic              mem_writeStatus;
  logic              busy;
  logic              err;

  // Arbiter side: serves the requesters and drives the RAM strobes.
  modport slave (
    input  ld_req, ld_addr, st_req, st_addr, st_data,
    input  mem_Dataout, mem_readStatus, mem_writeStatus,
    output ld_ack, ld_data, st_ack,
    output mem_address, mem_writeData, mem_nRD, mem_nWR, busy, err
  );

  // Environment side: requesters plus the RAM itself.
  modport master (
    output ld_req, ld_addr, st_req, st_addr, st_data,
    output mem_Dataout, mem_readStatus, mem_writeStatus,
    input  ld_ack, ld_data, st_ack,
    input  mem_address, mem_writeData, mem_nRD, mem_nWR, busy, err
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// rtl/mem_arbiter_pick.sv - combinational two-way winner select between load and store
module arb_pick import mem_pkg::*; #(
  parameter bit PRIO_STORE = 1'b0
) (
  input  logic   ld_req,
  input  logic   st_req,
  input  grant_t last_grant,
  output logic   valid,
  output grant_t grant
);

  // On a tie: fixed store priority, or hand the grant to whoever did not win last.
  always_comb begin
    valid = ld_req | st_req;
    grant = GRANT_LD;
    if (ld_req && st_req) begin
      if (PRIO_STORE)
        grant = GRANT_ST;
      else if (last_grant == GRANT_ST)
        grant = GRANT_LD;
      else
        grant = GRANT_ST;
    end else if (st_req) begin
      grant = GRANT_ST;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - load/store arbiter for the shared RAM; ARB_TIMEOUT_EN adds wait-state abort
module mem_arbiter import mem_pkg::*; #(
  parameter bit PRIO_STORE  = 1'b0,
  parameter int TIMEOUT_CYC = 64
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  arb_state_t state;
  arb_state_t state_nxt;
  grant_t     last_grant;
  grant_t     pick;
  logic       pick_valid;
  logic       wait_expired;

  arb_pick #(.PRIO_STORE(PRIO_STORE)) u_pick (
    .ld_req     (bus.ld_req),
    .st_req     (bus.st_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .grant      (pick)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt;

  assign wait_expired = (wait_cnt == WAIT_LAST);

  // Wait counter: every wait state is entered from IDLE, so clearing there covers entry.
  always_ff @(posedge clk) begin
    if (reset || state == ARB_IDLE)
      wait_cnt <= '0;
    else if (state == ARB_RD || state == ARB_WR)
      wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign wait_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= ARB_IDLE;
    else
      state <= state_nxt;
  end

  // Next state: requests only matter in IDLE, completion status only in the matching wait.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (pick_valid) state_nxt = (pick == GRANT_ST) ? ARB_WR : ARB_RD;
      ARB_RD:   if (bus.mem_readStatus || wait_expired) state_nxt = ARB_REL;
      ARB_WR:   if (bus.mem_writeStatus || wait_expired) state_nxt = ARB_REL;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // Combinational status output.
  always_comb begin
    bus.busy = (state != ARB_IDLE);
  end

  // Registered bus side: latch the winner's request, hold it through the wait, pulse the ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_nRD       <= 1'b1;
      bus.mem_nWR       <= 1'b1;
      bus.mem_address   <= '0;
      bus.mem_writeData <= '0;
      bus.ld_data       <= '0;
      bus.ld_ack        <= 1'b0;
      bus.st_ack        <= 1'b0;
      bus.err           <= 1'b0;
      last_grant        <= GRANT_ST;
    end else begin
      bus.ld_ack <= 1'b0;
      bus.st_ack <= 1'b0;
      bus.err    <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            last_grant <= pick;
            if (pick == GRANT_ST) begin
              bus.mem_address   <= bus.st_addr;
              bus.mem_writeData <= bus.st_data;
              bus.mem_nWR       <= 1'b0;
            end else begin
              bus.mem_address <= bus.ld_addr;
              bus.mem_nRD     <= 1'b0;
            end
          end
        end
        ARB_RD: begin
          if (bus.mem_readStatus) begin
            bus.ld_data <= bus.mem_Dataout;
            bus.ld_ack  <= 1'b1;
            bus.mem_nRD <= 1'b1;
          end else if (wait_expired) begin
            bus.ld_ack  <= 1'b1;
            bus.err     <= 1'b1;
            bus.mem_nRD <= 1'b1;
          end
        end
        ARB_WR: begin
          if (bus.mem_writeStatus) begin
            bus.st_ack  <= 1'b1;
            bus.mem_nWR <= 1'b1;
          end else if (wait_expired) begin
            bus.st_ack  <= 1'b1;
            bus.err     <= 1'b1;
            bus.mem_nWR <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
